// File: rtl/led_fade_sequencer.sv
// led_fade_sequencer: turns button presses into RGB preset targets and fades
// the live colour one LSB per step, stepping only on PWM period boundaries.
module led_fade_sequencer #(
  parameter int unsigned STEP_PERIODS = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  btn,
  output logic [23:0] color,
  output logic [7:0]  pwm_cnt,
  output logic        period_end,
  output logic        busy
);

  typedef enum logic {
    IDLE,
    FADE
  } state_t;

  localparam logic [7:0] LAST = 8'(STEP_PERIODS - 1);

  state_t      state_q;
  logic [7:0]  cnt_q;
  logic [7:0]  btn_q;
  logic [7:0]  step_q;
  logic [23:0] color_q;
  logic [23:0] color_d;
  logic [23:0] target_q;
  logic [23:0] target_d;
  logic [23:0] preset;
  logic [7:0]  req;
  logic [7:0]  req_lo;
  logic        has_req;
  logic        do_step;

  function automatic logic [7:0] toward(
    input logic [7:0] c,
    input logic [7:0] t
  );
    logic [7:0] r;
    r = c;
    if (c < t) r = c + 8'd1;
    else if (c > t) r = c - 8'd1;
    return r;
  endfunction

  assign period_end = (cnt_q == 8'hFF);

  // Isolating the lowest set request bit gives a one-hot select.
  always_comb begin
    req     = btn & ~btn_q;
    req_lo  = req & (~req + 8'd1);
    has_req = |req;
    preset  = '0;
    unique case (1'b1)
      req_lo[0]: preset = 24'hFF0000;
      req_lo[1]: preset = 24'hFF8000;
      req_lo[2]: preset = 24'hFFFF00;
      req_lo[3]: preset = 24'h00FF00;
      req_lo[4]: preset = 24'h0000FF;
      req_lo[5]: preset = 24'h4B0082;
      req_lo[6]: preset = 24'h8F00FF;
      req_lo[7]: preset = 24'h000000;
      default:   preset = '0;
    endcase
  end

  always_comb begin
    do_step  = (state_q == FADE) && period_end && (step_q == LAST);
    color_d  = color_q;
    target_d = target_q;
    if (do_step) begin
      color_d = {toward(color_q[23:16], target_q[23:16]),
                 toward(color_q[15:8],  target_q[15:8]),
                 toward(color_q[7:0],   target_q[7:0])};
    end
    if (has_req) target_d = preset;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      btn_q    <= '0;
      step_q   <= '0;
      color_q  <= '0;
      target_q <= '0;
    end else begin
      cnt_q    <= cnt_q + 8'd1;
      btn_q    <= btn;
      color_q  <= color_d;
      target_q <= target_d;
      unique case (state_q)
        IDLE: begin
          step_q <= '0;
          if (has_req && (preset != color_q)) state_q <= FADE;
        end
        FADE: begin
          // Stepped colour is compared with the possibly reloaded target.
          if (color_d == target_d) begin
            state_q <= IDLE;
            step_q  <= '0;
          end else if (do_step) begin
            step_q <= '0;
          end else if (period_end) begin
            step_q <= step_q + 8'd1;
          end
        end
      endcase
    end
  end

  assign color   = color_q;
  assign pwm_cnt = cnt_q;
  assign busy    = (state_q == FADE);

endmodule

// File: doc/led_fade_sequencer.md
# led_fade_sequencer

Colour sequencer for the three-channel RGB PWM LED datapath. It turns one-hot button requests into a 24-bit target colour and fades the live colour toward that target, one LSB per channel per step. It also runs the shared 8-bit PWM period counter, so colour changes land only on PWM period boundaries. Its outputs feed the per-channel PWM comparators that drive the R/G/B LED signals.

## Interface
- STEP_PERIODS, 4: PWM periods (256 clk each) per fade step; legal range 1..255.
- clk  in  1  system clock (1 MHz nominal, period 1000 ns)
- rst  in  1  asynchronous, active-low reset
- btn  in  8  colour request buttons, level inputs, one bit per preset
- color  out  24  live colour {R[23:16], G[15:8], B[7:0]} to the PWM comparators
- pwm_cnt  out  8  shared PWM period counter
- period_end  out  1  high while pwm_cnt == 255 (combinational from pwm_cnt)
- busy  out  1  high while a fade is in progress

## Operation
- Presets, selected by btn bit:
  - 0 red FF0000, 1 orange FF8000, 2 yellow FFFF00, 3 green 00FF00
  - 4 blue 0000FF, 5 indigo 4B0082, 6 violet 8F00FF, 7 off 000000
- pwm_cnt: free-running, +1 every clk, wraps 255 -> 0.
- Edge detect:
  - btn_q <= btn every clk.
  - req = btn & ~btn_q.
  - A held button yields exactly one request.
  - Several req bits set in the same cycle: lowest index wins; the others are discarded.
- Registers: target (24 b), color (24 b), step_cnt (8 b), state ∈ {IDLE, FADE}.
- IDLE:
  - step_cnt held at 0.
  - On req with preset != color: load target, go to FADE.
  - On req with preset == color: load target, stay IDLE, busy stays 0.
- FADE:
  - step_cnt increments on each period_end cycle.
  - On a period_end cycle with step_cnt == STEP_PERIODS-1, clear step_cnt and apply one step.
  - Step: each channel independently moves +1 toward its target if below, −1 if above, unchanged if equal; 8-bit unsigned, no wrap.
  - If color equals target after the step, go to IDLE in the same edge.
- Retarget in FADE:
  - A new req reloads target immediately.
  - step_cnt is not cleared; the fade continues from the current color.
  - If the new target equals the current color, go to IDLE at that edge.
  - If req and a step edge coincide, the step uses the old target and target loads the new value. The IDLE check compares the stepped color with the new target.
- busy = (state == FADE).

## Timing
- Reset values (all immediate, no clock needed): color 000000, target 000000, pwm_cnt 0, step_cnt 0, btn_q 00, state IDLE, busy 0, period_end 0.
- Request latency: btn rises before edge E (btn_q still 0). At edge E, target and state update, so busy is high in the cycle after E.
- Step timing: color changes only on the edge that ends a period_end cycle, i.e. coincident with pwm_cnt 255 -> 0. The comparator never sees a mid-period change.
- First step: at the STEP_PERIODS-th period_end after FADE entry. Entry mid-period counts the partial period.
- Fade duration: max(|ΔR|, |ΔG|, |ΔB|) steps, each STEP_PERIODS × 256 clk apart.
  - Full 00 -> FF with STEP_PERIODS = 4 takes 255 × 1024 clk.
- busy falls on the same edge as the final step.
- Reset asserted mid-fade clears everything asynchronously. After release, pwm_cnt restarts from 0 on the first edge.

## Test plan
- Reset/counter: hold rst=0 with clk running -> color 000000, busy 0, pwm_cnt 0. Release -> pwm_cnt counts 0..255, period_end high exactly 1 cycle in 256.
- Basic fade (STEP_PERIODS=1): pulse btn[0] from reset -> busy=1 next cycle. R increments by 1 at every pwm_cnt 255 -> 0 wrap. color = FF0000 after 255 steps, busy falls on that edge.
- Priority: btn = 8'b00100100 in one cycle -> target FFFF00 (yellow), indigo ignored. Channels reach FFFF00, then busy = 0.
- Retarget: while fading toward red, at color 400000 press btn[4] -> R steps down, B steps up each step. Reaches 0000FF after 255 steps (limited by B); step cadence unbroken at the switch.
- Held/same button:
  - Hold btn[1] for 5000 clk -> exactly one request.
  - After reaching FF8000, press btn[1] again -> busy stays 0, color unchanged.
- Async reset mid-fade: drive rst low between clock edges at color 3A0000 -> color 000000 and busy 0 before the next edge. No fade resumes after release.
